// File: rtl/sort_controller.sv
// sort_controller: odd-even transposition sort sequencer (optional SORT_FINISH_HOLD_EN holds finish while sort_en stays high)
module sort_controller #(
  parameter int N  = 8,
  parameter int PW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic sort_en,
  output logic sort_finish,
  output logic even_cmp_en,
  output logic even_L,
  output logic even_R,
  output logic odd_cmp_en,
  output logic odd_L,
  output logic odd_R
);
  typedef enum logic [1:0] {IDLE, CMP, WB, DONE} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic last, odd;
  assign last = phase_q == PW'(N - 1);
  assign odd  = phase_q[0];
  // state and phase registers, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end
  // next state plus Moore decode of the strobes from registered state and phase
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sort_finish = state_q == DONE;
    even_cmp_en = state_q == CMP && !odd;
    odd_cmp_en  = state_q == CMP && odd;
    even_L      = state_q == WB && !odd;
    even_R      = state_q == WB && !odd;
    odd_L       = state_q == WB && odd;
    odd_R       = state_q == WB && odd;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        state_d = sort_en ? CMP : IDLE;
      end
      CMP: state_d = WB;
      WB: begin
        state_d = last ? DONE : CMP;
        phase_d = last ? phase_q : phase_q + PW'(1);
      end
`ifdef SORT_FINISH_HOLD_EN
      DONE: state_d = sort_en ? DONE : IDLE;
`else
      DONE: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sort_controller.sv
// tb_sort_controller: directed vector bench for sort_controller at N=8 and N=5
module tb_sort_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en8 = 1'b0;
  logic en5 = 1'b0;
  logic fin8, ec8, el8, er8, oc8, ol8, or8;
  logic fin5, ec5, el5, er5, oc5, ol5, or5;
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] EC = 7'b0100000;
  localparam logic [6:0] EW = 7'b0011000;
  localparam logic [6:0] OC = 7'b0000100;
  localparam logic [6:0] OW = 7'b0000011;
  localparam logic [6:0] FN = 7'b1000000;

  always #5 clk = ~clk;

  sort_controller #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .sort_en(en8), .sort_finish(fin8),
    .even_cmp_en(ec8), .even_L(el8), .even_R(er8),
    .odd_cmp_en(oc8), .odd_L(ol8), .odd_R(or8)
  );

  sort_controller #(.N(5)) dut5 (
    .clk(clk), .rst(rst), .sort_en(en5), .sort_finish(fin5),
    .even_cmp_en(ec5), .even_L(el5), .even_R(er5),
    .odd_cmp_en(oc5), .odd_L(ol5), .odd_R(or5)
  );

  wire [6:0] o8 = {fin8, ec8, el8, er8, oc8, ol8, or8};
  wire [6:0] o5 = {fin5, ec5, el5, er5, oc5, ol5, or5};

  typedef struct {
    logic       rst;
    logic       en;
    logic [6:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_excl(input string name);
    int g;
    g = int'(ec8) + int'(el8 | er8) + int'(oc8) + int'(ol8 | or8);
    n_chk++;
    if (g > 1) begin
      n_fail++;
      $display("FAIL %s: %0d groups active, at most 1 allowed", name, g);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t tv[22];
  logic [6:0] seq5[12];

  initial begin
    tv[0]  = '{1'b0, 1'b1, Z};
    tv[1]  = '{1'b0, 1'b1, Z};
    tv[2]  = '{1'b0, 1'b1, Z};
    tv[3]  = '{1'b1, 1'b1, EC};
    tv[4]  = '{1'b1, 1'b1, EW};
    tv[5]  = '{1'b1, 1'b1, OC};
    tv[6]  = '{1'b1, 1'b1, OW};
    tv[7]  = '{1'b1, 1'b1, EC};
    tv[8]  = '{1'b1, 1'b1, EW};
    tv[9]  = '{1'b1, 1'b0, OC};
    tv[10] = '{1'b1, 1'b0, OW};
    tv[11] = '{1'b1, 1'b0, EC};
    tv[12] = '{1'b1, 1'b0, EW};
    tv[13] = '{1'b1, 1'b0, OC};
    tv[14] = '{1'b1, 1'b0, OW};
    tv[15] = '{1'b1, 1'b0, EC};
    tv[16] = '{1'b1, 1'b0, EW};
    tv[17] = '{1'b1, 1'b0, OC};
    tv[18] = '{1'b1, 1'b0, OW};
    tv[19] = '{1'b1, 1'b0, FN};
    tv[20] = '{1'b1, 1'b0, Z};
    tv[21] = '{1'b1, 1'b0, Z};
    seq5 = '{EC, EW, OC, OW, EC, EW, OC, OW, EC, EW, FN, Z};

    #1;
    chk("reset_async_n8", o8, Z);
    chk("reset_async_n5", o5, Z);

    for (int i = 0; i < 22; i++) begin
      rst = tv[i].rst;
      en8 = tv[i].en;
      tick();
      chk($sformatf("vec%0d", i), o8, tv[i].exp);
      chk_excl($sformatf("excl%0d", i));
    end

    en5 = 1'b1;
    tick();
    chk("n5_start", o5, seq5[0]);
    en5 = 1'b0;
    for (int i = 1; i < 12; i++) begin
      tick();
      chk($sformatf("n5_cyc%0d", i), o5, seq5[i]);
    end

    en8 = 1'b1;
    tick();
    chk("rs_start", o8, EC);
    en8 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rs_phase3_cmp", o8, OC);
    #2 rst = 1'b0;
    #1;
    chk("rs_async_clear", o8, Z);
    tick();
    chk("rs_held", o8, Z);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("rs_quiet%0d", i), o8, Z);
    end

    begin
      int k;
      en8 = 1'b1;
      tick();
      chk("hi_start", o8, EC);
      k = 0;
      while (!fin8 && k < 40) begin
        tick();
        k++;
      end
      n_chk++;
      if (k != 16) begin
        n_fail++;
        $display("FAIL hi_latency: finish after %0d edges, expected 16", k);
      end
    end
`ifdef SORT_FINISH_HOLD_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold%0d", i), o8, FN);
    end
    en8 = 1'b0;
    tick();
    chk("hold_release", o8, Z);
    tick();
    chk("hold_idle", o8, Z);
`else
    tick();
    chk("pulse_idle", o8, Z);
    tick();
    chk("pulse_restart", o8, EC);
    tick();
    chk("pulse_restart_wb", o8, EW);
    en8 = 1'b0;
`endif
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("final_idle", o8, Z);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sort_controller.md
# sort_controller

Sequencing controller for an odd-even transposition sorter built from a linear array of N compare-exchange cells. On a start request it runs exactly N alternating phases, even first. Each phase has a compare cycle and a write-back cycle. The controller produces the comparator enables and the left/right register write-back strobes for the even-pair and odd-pair networks, then reports completion. It sits between the top-level control and the sorter datapath; it carries no data.

## Interface
Parameters:
- N, default 8: number of elements sorted; legal range N ≥ 2.
- PW, default $clog2(N): phase counter width.

Ports:
- clk  input  1  the single system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous and active-low (asserted when 0).
- sort_en  input  1  start request; level-sampled in IDLE.
- sort_finish  output  1  sort complete indication.
- even_cmp_en  output  1  enables the even-pair comparators (pairs 0-1, 2-3, …).
- even_L  output  1  write-back strobe for the left (lower index) cell of each even pair; that cell loads min.
- even_R  output  1  write-back strobe for the right cell of each even pair; that cell loads max.
- odd_cmp_en  output  1  enables the odd-pair comparators (pairs 1-2, 3-4, …).
- odd_L  output  1  write-back strobe for the left cell of each odd pair; that cell loads min.
- odd_R  output  1  write-back strobe for the right cell of each odd pair; that cell loads max.

## Operation
- The FSM has four states: IDLE, CMP, WB, DONE. A phase counter `phase` (PW bits) counts 0..N-1.
- In IDLE:
  - If sort_en=1, go to CMP with phase=0.
  - Otherwise stay in IDLE.
- In CMP, always go to WB.
  - If phase is even, even_cmp_en=1.
  - If phase is odd, odd_cmp_en=1.
- In WB:
  - If phase is even, even_L=even_R=1. If phase is odd, odd_L=odd_R=1.
  - If phase=N-1, go to DONE. Otherwise increment phase and go to CMP.
- In DONE, sort_finish=1 (see Configuration for how DONE exits).
- All outputs are Moore decodes of the registered state and phase; there are no combinational paths from inputs to outputs.
- At most one of the six datapath outputs groups is active in any cycle: either one cmp_en, or one L/R pair. Even and odd signals are never high together.
- sort_en is ignored outside IDLE (and outside DONE when the hold macro is enabled). Deasserting it mid-sort does not abort the sort.

## Timing
- Reset value of every output is 0. State is IDLE and phase is 0 while rst=0, applied immediately (asynchronously).
- If sort_en is sampled high at edge t in IDLE:
  - CMP of phase 0 occupies cycle t+1.
  - WB of phase 0 occupies cycle t+2.
  - Phase p occupies cycles t+2p+1 (CMP) and t+2p+2 (WB).
  - sort_finish rises in cycle t+2N+1.
- Latency from start to finish is 2N+1 cycles. For N=8 that is 17.
- A reset asserted mid-sort returns to IDLE at once; no partial strobes follow.
- N odd: the last phase (N-1) is even.

## Configuration
- Macro SORT_FINISH_HOLD_EN.
- Without it:
  - DONE lasts exactly one cycle, so sort_finish is a 1-cycle pulse.
  - DONE then goes to IDLE.
  - If sort_en is still high in IDLE, a new sort starts, with CMP two cycles after the finish pulse.
- With it:
  - DONE holds sort_finish=1 while sort_en=1.
  - When sort_en is sampled 0, DONE goes to IDLE and sort_finish drops the next cycle.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with sort_en=1 → all outputs 0, no activity. Release rst → even_cmp_en=1 one cycle after the first edge sampling sort_en=1.
- **Full sort, N=8:** pulse sort_en for 1 cycle.
  - even_cmp_en appears in 4 cycles and even_L/even_R in 4 cycles.
  - odd_cmp_en appears in 4 cycles and odd_L/odd_R in 4 cycles.
  - Each cmp_en cycle is followed immediately by the matching L/R cycle, and the pattern is strictly alternating even/odd.
  - sort_finish appears 17 cycles after the start edge.
- **Mutual exclusion:** over the full N=8 run, no cycle has more than one of {even_cmp_en, odd_cmp_en, even_L|even_R, odd_L|odd_R} high.
- **Odd N:** with N=5, the phase sequence is even, odd, even, odd, even, and sort_finish appears 11 cycles after the start edge.
- **Mid-sort events:**
  - Drop sort_en at phase 3 → the sort completes normally.
  - Assert rst at phase 3 → all outputs 0 immediately, and no sort_finish appears.
- **Finish mode with sort_en held high:**
  - Without SORT_FINISH_HOLD_EN → a 1-cycle finish pulse, then a restart.
  - With SORT_FINISH_HOLD_EN → sort_finish stays high until sort_en=0 is sampled, then clears one cycle later.
